snow64_memory_responder: RTL and testbench
==========================================

SNOW64_MEMORY_RESPONDER -- requirements
Module: snow64_memory_responder

Interface
REQ-001 Parameter WORDS_LOG2, default 10: log2 of the number of 64-bit words in the backing array (1024 words = 256 lines).
REQ-002 Parameter EXTRA_WAIT, default 2: idle latency cycles inserted before the first beat; legal range 0..15.
REQ-003 Port clk, input, 1: the single clock.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port in_req, input, 1: access request, level, four-phase.
REQ-006 Port in_addr, input, 64: byte address (CpuAddr).
REQ-007 Port in_data, input, 256: write line (LarData).
REQ-008 Port in_mem_acc_type, input, 1: 0 = MemAccTypRead, 1 = MemAccTypWrite.
REQ-009 Port out_valid, output, 1: access complete.
REQ-010 Port out_data, output, 256: read line.
REQ-011 The input and output bundles SHALL map bit-for-bit onto PartialPortOut_MemoryBusGuard_MemAccess and PartialPortIn_MemoryBusGuard_MemAccess, so the block is the memory-side responder of the bus guard.

Function
REQ-012 The block SHALL be a four-state FSM: StIdle, StWait, StBeat, StDone.
REQ-013 In StIdle with in_req=1, the block SHALL latch addr, data and type at that edge and go to StWait, or to StBeat if EXTRA_WAIT=0.
REQ-014 StWait SHALL last exactly EXTRA_WAIT cycles, counted by a 4-bit counter, then go to StBeat.
REQ-015 StBeat SHALL last exactly 4 cycles, with a 2-bit beat index 0..3 and one 64-bit word moved per cycle, then go to StDone.
REQ-016 Word address = {latched_addr[WORDS_LOG2+2:5], beat}; addr[4:0] SHALL be ignored; upper address bits SHALL be ignored, so addresses wrap modulo the array size.
REQ-017 Line word order SHALL be little-endian: beat i uses bits [64*i+63 : 64*i].
REQ-018 Read: each beat SHALL copy array[word] into that slice of a 256-bit line buffer.
REQ-019 Write: each beat SHALL write the latched data slice into array[word].
REQ-020 out_data SHALL be the line buffer; a write access SHALL clear it to 0.
REQ-021 out_valid SHALL be registered and equal to (state == StDone).
REQ-022 First out_valid SHALL appear EXTRA_WAIT+4 cycles after the accepting edge (6 cycles at default).
REQ-023 In StDone, out_valid and out_data SHALL hold until in_req is sampled 0, then the block SHALL go to StIdle, with out_valid low the following cycle.
REQ-024 While not in StIdle, changes on in_req, in_addr, in_data and in_mem_acc_type SHALL be ignored.
REQ-025 A request SHALL never be accepted in the same cycle as StDone exits, giving a minimum of one idle cycle between accesses.

Reset
REQ-026 rst SHALL asynchronously force StIdle, counters = 0, out_valid = 0 and line buffer = 0.
REQ-027 Array contents SHALL not be reset; a write interrupted by reset leaves a partial line (earlier beats written, later beats not).
REQ-028 After rst deasserts, the first edge with in_req=1 SHALL start a fresh access.

Structure
REQ-029 The State enum and a MSB_POS__SNOW64_MEMORY_RESPONDER__STATE define SHALL be added to a shared PkgSnow64MemoryResponder package; CpuAddr, LarData and MemAccessType SHALL be reused from PkgSnow64MemoryBusGuard.
REQ-030 The array SHALL be one sub-module, snow64_word_ram: 64-bit words, asynchronous read, synchronous write, no reset.
REQ-031 Target size is 150-250 RTL lines.

Verification
REQ-032 Write line 0x0123..(pattern A) to addr 0x40; then read 0x40 -> out_valid 6 cycles after each acceptance and out_data == A.
REQ-033 Read addr 0x5F -> same line as 0x40 (low bits ignored); read 0x40 + 0x2000 (1024 words) -> alias, returns A.
REQ-034 Hold in_req=1 for 10 cycles after out_valid -> out_valid stays 1 and no second access starts; drop in_req -> out_valid 0 next cycle, then a new req is accepted.
REQ-035 EXTRA_WAIT=0 build: back-to-back write then read -> valid at 4 cycles each, with one idle cycle between accesses.
REQ-036 Assert rst during beat 2 of a write of pattern B to 0x80 -> out_valid 0 immediately; a read of 0x80 returns B in words 0-1 and old data in words 2-3.
REQ-037 Change in_addr and in_data mid-access -> result reflects only the values latched at acceptance.

Source files
------------

// File: rtl/snow64_memory_responder_pkg.sv
// Shared bus-guard types and the memory responder FSM encoding.
// The responder reuses the bus guard's address, line and access-type types.
`ifndef MSB_POS__SNOW64_MEMORY_RESPONDER__STATE
`define MSB_POS__SNOW64_MEMORY_RESPONDER__STATE 1
`endif

package PkgSnow64MemoryBusGuard;
  typedef logic [63:0]  CpuAddr;
  typedef logic [255:0] LarData;

  typedef enum logic {
    MemAccTypRead  = 1'b0,
    MemAccTypWrite = 1'b1
  } MemAccessType;

  // Request bundle driven by the bus guard towards memory.
  typedef struct packed {
    logic         req;
    CpuAddr       addr;
    LarData       data;
    MemAccessType mem_acc_type;
  } PartialPortOut_MemoryBusGuard_MemAccess;

  // Response bundle returned by memory to the bus guard.
  typedef struct packed {
    logic   valid;
    LarData data;
  } PartialPortIn_MemoryBusGuard_MemAccess;
endpackage

package PkgSnow64MemoryResponder;
  typedef enum logic [`MSB_POS__SNOW64_MEMORY_RESPONDER__STATE:0] {
    StIdle,
    StWait,
    StBeat,
    StDone
  } State;

  localparam int WORD_W     = 64;
  localparam int LINE_WORDS = 4;
endpackage

// File: rtl/snow64_word_ram.sv
// 64-bit word array: asynchronous read, synchronous write, contents never reset.
module snow64_word_ram #(
  parameter int WORDS_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [WORDS_LOG2-1:0] addr_i,
  input  logic [63:0]           wdata_i,
  output logic [63:0]           rdata_o
);
  logic [63:0] mem_q [2**WORDS_LOG2];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/snow64_memory_responder.sv
// Memory-side responder of the bus guard: latches one line access, waits
// EXTRA_WAIT cycles, moves four 64-bit beats, then holds the result until req drops.
module snow64_memory_responder
  import PkgSnow64MemoryBusGuard::*;
  import PkgSnow64MemoryResponder::*;
#(
  parameter int WORDS_LOG2 = 10,
  parameter int EXTRA_WAIT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_req,
  input  logic [63:0]  in_addr,
  input  logic [255:0] in_data,
  input  logic         in_mem_acc_type,
  output logic         out_valid,
  output logic [255:0] out_data
);
  localparam logic [3:0] WAIT_LAST = 4'(EXTRA_WAIT - 1);

  // Handshake: four-phase. req is sampled only in StIdle; valid rises in StDone
  // and stays high (with data stable) until req is seen low, then one idle cycle.
  PartialPortOut_MemoryBusGuard_MemAccess req_bus;
  PartialPortIn_MemoryBusGuard_MemAccess  resp_bus;

  assign req_bus = {in_req, in_addr, in_data, MemAccessType'(in_mem_acc_type)};
  assign {out_valid, out_data} = resp_bus;

  State                  state_q;
  logic [3:0]            wait_cnt_q;
  logic [1:0]            beat_q;
  logic [WORDS_LOG2-3:0] line_addr_q;
  LarData                wdata_q;
  MemAccessType          type_q;
  LarData                line_q;
  logic                  valid_q;

  logic                  ram_we;
  logic [WORDS_LOG2-1:0] ram_addr;
  logic [63:0]           ram_rdata;
  logic                  unused_addr_bits;

  // Offset bits and bits above the array size do not select a word.
  assign unused_addr_bits = ^{req_bus.addr[63:WORDS_LOG2+3], req_bus.addr[4:0]};

  assign ram_addr = {line_addr_q, beat_q};
  assign ram_we   = (state_q == StBeat) && (type_q == MemAccTypWrite);

  snow64_word_ram #(
    .WORDS_LOG2(WORDS_LOG2)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (wdata_q[WORD_W*beat_q +: WORD_W]),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      beat_q      <= '0;
      line_addr_q <= '0;
      wdata_q     <= '0;
      type_q      <= MemAccTypRead;
      line_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_bus.req) begin
            line_addr_q <= req_bus.addr[WORDS_LOG2+2:5];
            wdata_q     <= req_bus.data;
            type_q      <= req_bus.mem_acc_type;
            wait_cnt_q  <= '0;
            beat_q      <= '0;
            if (req_bus.mem_acc_type == MemAccTypWrite) line_q <= '0;
            state_q     <= (EXTRA_WAIT == 0) ? StBeat : StWait;
          end
        end
        StWait: begin
          if (wait_cnt_q == WAIT_LAST) begin
            wait_cnt_q <= '0;
            state_q    <= StBeat;
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end
        StBeat: begin
          if (type_q == MemAccTypRead) line_q[WORD_W*beat_q +: WORD_W] <= ram_rdata;
          beat_q <= beat_q + 2'd1;
          if (beat_q == 2'(LINE_WORDS - 1)) begin
            state_q <= StDone;
            valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (!req_bus.req) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign resp_bus = {valid_q, line_q};
endmodule

// File: tb/tb_snow64_memory_responder.sv
// Bench for the memory responder: two builds (EXTRA_WAIT=2 and 0) checked every
// cycle against a line-level access model, plus literal expectations.
module tb_snow64_memory_responder;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req = 2'b00;
  logic [63:0]  addr = '0;
  logic [255:0] wdata = '0;
  logic         typ = 1'b0;
  logic [1:0]   valid;
  logic [255:0] odata [2];

  int n_vec = 0;
  int n_err = 0;

  localparam logic [255:0] PAT_A = 256'h0123456789abcdef_1122334455667788_99aabbccddeeff00_fedcba9876543210;
  localparam logic [255:0] PAT_B = 256'hb0b0b0b0b0b0b0b0_b1b1b1b1b1b1b1b1_b2b2b2b2b2b2b2b2_b3b3b3b3b3b3b3b3;
  localparam logic [255:0] PAT_O = 256'h0d0d0d0d0d0d0d0d_1d1d1d1d1d1d1d1d_2d2d2d2d2d2d2d2d_3d3d3d3d3d3d3d3d;
  localparam logic [255:0] PAT_C = 256'hc0ffee00c0ffee01_c0ffee02c0ffee03_c0ffee04c0ffee05_c0ffee06c0ffee07;
  localparam logic [255:0] PAT_D = 256'hdddd0000dddd0001_dddd0002dddd0003_dddd0004dddd0005_dddd0006dddd0007;

  always #5 clk = ~clk;

  snow64_memory_responder u_dut0 (
    .clk             (clk),
    .rst             (rst),
    .in_req          (req[0]),
    .in_addr         (addr),
    .in_data         (wdata),
    .in_mem_acc_type (typ),
    .out_valid       (valid[0]),
    .out_data        (odata[0])
  );

  snow64_memory_responder #(.WORDS_LOG2(10), .EXTRA_WAIT(0)) u_dut1 (
    .clk             (clk),
    .rst             (rst),
    .in_req          (req[1]),
    .in_addr         (addr),
    .in_data         (wdata),
    .in_mem_acc_type (typ),
    .out_valid       (valid[1]),
    .out_data        (odata[1])
  );

  // ---------------- behavioural model ----------------
  // An access accepted at edge 0 completes at edge EXTRA_WAIT+4; write word i
  // lands at edge EXTRA_WAIT+1+i. Word index = line (addr/32 mod 256) * 4 + i.
  logic [63:0]  mmem [2][1024];
  bit           m_busy [2] = '{0, 0};
  bit           m_done [2] = '{0, 0};
  int           m_age  [2] = '{0, 0};
  bit           m_wr   [2] = '{0, 0};
  logic [63:0]  m_addr [2];
  logic [255:0] m_data [2];
  logic [255:0] m_line [2] = '{256'h0, 256'h0};

  function automatic int extra_wait(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic int word_idx(input logic [63:0] a, input int b);
    return int'((a >> 5) % 64'd256) * 4 + b;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        if (m_busy[d] && m_wr[d] && !m_done[d]) begin
          for (int b = 0; b < 4; b++)
            if (b < m_age[d] - extra_wait(d)) mmem[d][word_idx(m_addr[d], b)] = m_data[d][64*b +: 64];
        end
        m_busy[d] = 0;
        m_done[d] = 0;
        m_line[d] = '0;
      end else if (!m_busy[d]) begin
        if (req[d]) begin
          m_busy[d] = 1;
          m_age[d]  = 0;
          m_wr[d]   = typ;
          m_addr[d] = addr;
          m_data[d] = wdata;
          if (typ) m_line[d] = '0;
        end
      end else if (!m_done[d]) begin
        m_age[d]++;
        if (m_age[d] == extra_wait(d) + 4) begin
          m_done[d] = 1;
          for (int b = 0; b < 4; b++) begin
            if (m_wr[d]) mmem[d][word_idx(m_addr[d], b)] = m_data[d][64*b +: 64];
            else m_line[d][64*b +: 64] = mmem[d][word_idx(m_addr[d], b)];
          end
        end
      end else if (!req[d]) begin
        m_busy[d] = 0;
        m_done[d] = 0;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        n_vec++;
        if (valid[d] !== m_done[d]) begin
          n_err++;
          $display("FAIL valid_cycle dut%0d t=%0t: got %b want %b", d, $time, valid[d], m_done[d]);
        end
        if (m_done[d] || !m_busy[d]) begin
          n_vec++;
          if (odata[d] !== m_line[d]) begin
            n_err++;
            $display("FAIL data_cycle dut%0d t=%0t: got %h want %h", d, $time, odata[d], m_line[d]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic access(input int d, input logic [63:0] a, input logic [255:0] dat,
                        input logic wr, input int hold, input bit scramble, output int lat);
    addr  = a;
    wdata = dat;
    typ   = wr;
    req[d] = 1'b1;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (scramble && c == 1) begin
        addr  = {$urandom, $urandom};
        wdata = rnd256();
        typ   = ~typ;
      end
      if (valid[d] === 1'b1) begin
        lat = c - 1;
        break;
      end
    end
    if (lat < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout dut%0d: got no valid want valid within 40 cycles", d);
    end
    repeat (hold) @(negedge clk);
    req[d] = 1'b0;
    @(negedge clk);
    chk("valid_after_drop", {255'd0, valid[d]}, 256'd0);
  endtask

  task automatic chk_lat(input string name, input int d, input int lat);
    chk(name, 256'(lat), (d == 0) ? 256'd6 : 256'd4);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    logic [63:0] a;
    repeat (3) @(negedge clk);
    chk("reset_valid0", {255'd0, valid[0]}, 256'd0);
    chk("reset_data0", odata[0], 256'd0);
    rst = 1'b0;
    @(negedge clk);

    // Write then read back, including ignored offset bits and an aliased address.
    access(0, 64'h40, PAT_A, 1'b1, 0, 0, lat);
    chk_lat("lat_write_a", 0, lat);
    chk("write_clears_line", odata[0], 256'd0);
    access(0, 64'h40, 256'd0, 1'b0, 0, 0, lat);
    chk_lat("lat_read_a", 0, lat);
    chk("read_a", odata[0], PAT_A);
    access(0, 64'h5F, 256'd0, 1'b0, 0, 0, lat);
    chk("read_low_bits_ignored", odata[0], PAT_A);
    access(0, 64'h2040, 256'd0, 1'b0, 0, 0, lat);
    chk("read_alias", odata[0], PAT_A);

    // Long hold in Done, then an immediate new access.
    access(0, 64'h40, 256'd0, 1'b0, 10, 0, lat);
    chk_lat("lat_hold", 0, lat);
    access(0, 64'h40, 256'd0, 1'b0, 0, 0, lat);
    chk_lat("lat_after_hold", 0, lat);

    // Inputs changing mid-access must not leak in.
    access(0, 64'h60, PAT_C, 1'b1, 1, 1, lat);
    access(0, 64'h60, 256'd0, 1'b0, 0, 1, lat);
    chk("read_scrambled", odata[0], PAT_C);

    // Zero-wait build, back to back.
    access(1, 64'h100, PAT_D, 1'b1, 0, 0, lat);
    chk_lat("lat_write_nowait", 1, lat);
    access(1, 64'h100, 256'd0, 1'b0, 0, 0, lat);
    chk_lat("lat_read_nowait", 1, lat);
    chk("read_nowait", odata[1], PAT_D);

    // Reset during beat 2 of a write leaves a partial line.
    access(0, 64'h80, PAT_O, 1'b1, 0, 0, lat);
    addr = 64'h80;
    wdata = PAT_B;
    typ = 1'b1;
    req[0] = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("valid_on_reset", {255'd0, valid[0]}, 256'd0);
    @(negedge clk);
    req[0] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    access(0, 64'h80, 256'd0, 1'b0, 0, 0, lat);
    chk("partial_line", odata[0], {PAT_O[255:128], PAT_B[127:0]});

    // Randomized traffic over a small set of pre-written lines.
    for (int d = 0; d < 2; d++) begin
      for (int l = 0; l < 8; l++) access(d, 64'(l * 32), rnd256(), 1'b1, 0, 0, lat);
      for (int i = 0; i < 30; i++) begin
        a = {$urandom, $urandom};
        a[12:5] = 8'($urandom_range(0, 7));
        access(d, a, rnd256(), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), lat);
        chk_lat("lat_random", d, lat);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
